// File: rtl/gray_conv_pkg.sv
// Shared types and default widths for the Gray-converting round-robin arbiter.
package gray_conv_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int DEF_W  = 4;
  localparam int DEF_CW = 8;

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Two requester ports and one result port of the Gray converter arbiter.
interface gray_conv_arbiter_if
  import gray_conv_pkg::*;
#(
  parameter int W = DEF_W
);
  logic         req0_valid;
  logic [W-1:0] req0_bin;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_bin;
  logic         req1_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gray;
  logic         out_id;

  modport master (
    output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    input  req0_ready, req1_ready, out_valid, out_gray, out_id
  );

  modport slave (
    input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    output req0_ready, req1_ready, out_valid, out_gray, out_id
  );
endinterface

// File: rtl/bin2gray_core.sv
// Combinational binary to reflected-Gray converter.
module bin2gray_core
  import gray_conv_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  // MSB passes through; every lower bit is the XOR with its upper neighbour.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared Gray converter into a single-entry
// output register, with saturating per-requester grant counters.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_conv_arbiter_if.slave   bus,
  output logic [CW-1:0]        gnt_cnt0,
  output logic [CW-1:0]        gnt_cnt1
);

  state_t       state;
  state_t       next_state;
  logic         prio;
  logic         full;
  logic         any_valid;
  logic         load_en;
  logic         gnt_id;
  logic [W-1:0] sel_bin;
  logic [W-1:0] conv_gray;
  logic [W-1:0] gray_q;
  logic         id_q;

  assign full      = (state == FULL);
  assign any_valid = bus.req0_valid | bus.req1_valid;
  // Reset gates acceptance so nothing is taken while the block is being cleared.
  assign load_en   = (!full | bus.out_ready) & any_valid & !rst;
  assign gnt_id    = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;
  assign sel_bin   = gnt_id ? bus.req1_bin : bus.req0_bin;

  assign bus.req0_ready = load_en & !gnt_id;
  assign bus.req1_ready = load_en &  gnt_id;
  assign bus.out_valid  = full;
  assign bus.out_gray   = gray_q;
  assign bus.out_id     = id_q;

  bin2gray_core #(.W(W)) u_core (
    .bin  (sel_bin),
    .gray (conv_gray)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (load_en) next_state = FULL;
      FULL:  if (bus.out_ready && !load_en) next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q   <= '0;
      id_q     <= 1'b0;
      prio     <= 1'b0;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (load_en) begin
      gray_q <= conv_gray;
      id_q   <= gnt_id;
      prio   <= ~gnt_id;
      if (!gnt_id && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if ( gnt_id && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter: W, 4, data width of binary input and Gray output.
REQ-002 Parameter: CW, 8, width of per-requester grant counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req0_valid  input  1  requester 0 has a binary word pending.
REQ-006 req0_bin  input  W  requester 0 binary word.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 has a binary word pending.
REQ-009 req1_bin  input  W  requester 1 binary word.
REQ-010 req1_ready  output  1  requester 1 word accepted this cycle.
REQ-011 out_valid  output  1  out_gray/out_id hold a result.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 out_gray  output  W  Gray-coded result.
REQ-014 out_id  output  1  index of requester that produced out_gray.
REQ-015 gnt_cnt0  output  CW  saturating count of words accepted from requester 0.
REQ-016 gnt_cnt1  output  CW  saturating count of words accepted from requester 1.

Function
REQ-017 Conversion SHALL be out_gray[W-1] = bin[W-1], out_gray[i] = bin[i+1] XOR bin[i] for i < W-1; for W=4 it SHALL match the standard 4-bit reflected Gray table exactly.
REQ-018 One shared converter instance SHALL serve both requesters; the input mux selects the granted requester's word.
REQ-019 Output stage SHALL be a single register; load_en = (!out_valid | out_ready) & (req0_valid | req1_valid).
REQ-020 Latency: word accepted in cycle N SHALL appear on out_gray with out_valid=1 in cycle N+1.
REQ-021 Throughput: with out_ready held high, one word SHALL be accepted every cycle.
REQ-022 reqX_ready SHALL be combinational: asserted only for the granted requester, only when load_en=1; never both in the same cycle.
REQ-023 Arbitration SHALL be round-robin via a 1-bit priority pointer prio: when only one requester is valid it is granted; when both are valid, requester prio is granted.
REQ-024 After a grant to requester k, prio SHALL become 1-k; prio SHALL NOT change in cycles without a grant.
REQ-025 FSM states: EMPTY (out_valid=0), FULL (out_valid=1). EMPTY->FULL on load; FULL->EMPTY on out_ready with no load; FULL->FULL on out_ready with load (result replaced) or on !out_ready (result, id held stable).
REQ-026 While out_valid=1 and out_ready=0, out_gray and out_id SHALL NOT change and both reqX_ready SHALL be 0.
REQ-027 gnt_cntX SHALL increment by 1 on each accepted word from requester X and saturate at 2^CW-1 (no wrap).
REQ-028 Inputs of a non-granted requester SHALL be ignored; that requester must hold req_valid/req_bin until its ready.

Reset
REQ-029 On rst=1 at a clock edge: out_valid=0, out_gray=0, out_id=0, prio=0, gnt_cnt0=0, gnt_cnt1=0, FSM=EMPTY.
REQ-030 While rst=1, req0_ready and req1_ready SHALL be 0; a result pending when reset asserts SHALL be discarded and not presented afterwards.
REQ-031 First cycle after reset release SHALL accept a word if any requester is valid.

Structure
REQ-032 Shared package gray_conv_pkg SHALL hold the FSM state enum (EMPTY, FULL) and default W/CW constants.
REQ-033 Conversion SHALL be a sub-module bin2gray_core (combinational, parameter W); arbiter, output register and counters stay in gray_conv_arbiter.

Verification
REQ-034 Sweep: only req0 valid, bin 0..15, out_ready=1 -> out_gray sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, out_id=0, one result per cycle after 1-cycle latency.
REQ-035 Both valid every cycle, req0_bin=4'b0101, req1_bin=4'b1010, out_ready=1 -> grants alternate 0,1,0,1; out_gray alternates 4'b0111, 4'b1111.
REQ-036 Backpressure: result 4'b1100 (from bin 4'b1000) held with out_ready=0 for 5 cycles -> out_gray stable, both readys 0; out_ready=1 -> next word loads same cycle.
REQ-037 Saturation: CW=8, 300 accepted words from requester 1 -> gnt_cnt1=255, gnt_cnt0=0.
REQ-038 Reset mid-operation: out_valid=1 with out_ready=0, assert rst one cycle -> out_valid=0, counters 0, prio=0; next cycle with both valid grants requester 0.
